// File: rtl/audio_adc_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : audio_adc_rx
// Purpose  : Stereo I2S-style ADC receiver (master), left-justified capture
//            into a first-word-fall-through stereo frame FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module audio_adc_rx #(
   parameter int REF_CLK     = 18432000,
   parameter int SAMPLE_RATE = 48000,
   parameter int DATA_WIDTH  = 16,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          iCLK_18_4,
   input  logic                          iRST,
   input  logic                          iAUD_ADCDAT,
   output logic                          oAUD_BCK,
   output logic                          oAUD_ADCLRCK,
   input  logic                          iEN,
   input  logic                          iREAD,
   input  logic                          iCLR_OVF,
   output logic                          oVALID,
   output logic [DATA_WIDTH-1:0]         oLEFT,
   output logic [DATA_WIDTH-1:0]         oRIGHT,
   output logic [$clog2(FIFO_DEPTH):0]   oLEVEL,
   output logic                          oOVERFLOW
);

   localparam int c_HALF_BCK = REF_CLK / (SAMPLE_RATE * DATA_WIDTH * 4);
   localparam int c_BCK_PER  = 2 * c_HALF_BCK;
   localparam int c_FRAME    = 4 * c_HALF_BCK * DATA_WIDTH;
   localparam int c_CW       = $clog2(c_FRAME);
   localparam int c_PW       = $clog2(c_BCK_PER);
   localparam int c_AW       = $clog2(FIFO_DEPTH);
   localparam int c_LW       = c_AW + 1;

   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_FRAME - 1);
   localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(c_FRAME / 2);
   localparam logic [c_CW-1:0] c_CNT_PUSH = c_CW'(c_FRAME - c_HALF_BCK + 2);
   localparam logic [c_PW-1:0] c_PH_LAST  = c_PW'(c_BCK_PER - 1);
   localparam logic [c_PW-1:0] c_PH_HALF  = c_PW'(c_HALF_BCK);
   localparam logic [c_PW-1:0] c_PH_CAP   = c_PW'(c_HALF_BCK + 1);
   localparam logic [c_LW-1:0] c_LVL_FULL = c_LW'(FIFO_DEPTH);
   localparam logic [c_LW-1:0] c_LVL_ONE  = c_LW'(1);

   logic [c_CW-1:0]       r_cnt;
   logic [c_PW-1:0]       r_phase;
   logic                  r_bck;
   logic                  r_lrck;
   logic [1:0]            r_sync;
   logic [DATA_WIDTH-1:0] r_sh_l;
   logic [DATA_WIDTH-1:0] r_sh_r;
   logic                  r_arm;

   logic [DATA_WIDTH-1:0] r_mem_l [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_r [FIFO_DEPTH];
   logic [c_AW-1:0]       r_wptr;
   logic [c_AW-1:0]       r_rptr;
   logic [c_LW-1:0]       r_level;
   logic [DATA_WIDTH-1:0] r_left;
   logic [DATA_WIDTH-1:0] r_right;
   logic                  r_ovf;

   logic [c_CW-1:0] w_cnt_nxt;
   logic [c_PW-1:0] w_ph_nxt;
   logic            w_push;
   logic            w_full;
   logic            w_pop;
   logic            w_wr;
   logic            w_drop;
   logic [c_AW-1:0] w_rptr_nxt;
   logic [c_LW-1:0] w_level_nxt;

   assign w_cnt_nxt  = (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CW'(1);
   assign w_ph_nxt   = (r_phase == c_PH_LAST) ? '0 : r_phase + c_PW'(1);
   // iEN is also gated directly so that dropping it kills a pending push
   assign w_push     = (r_cnt == c_CNT_PUSH) && r_arm && iEN;
   assign w_full     = (r_level == c_LVL_FULL);
   assign w_pop      = iREAD && (r_level != '0);
   assign w_wr       = w_push && (!w_full || w_pop);
   assign w_drop     = w_push && w_full && !w_pop;
   assign w_rptr_nxt = w_pop ? r_rptr + c_AW'(1) : r_rptr;

   always_comb begin
      w_level_nxt = r_level;
      if (w_wr && !w_pop)
         w_level_nxt = r_level + c_LVL_ONE;
      else if (!w_wr && w_pop)
         w_level_nxt = r_level - c_LVL_ONE;
   end

   always_ff @(posedge iCLK_18_4 or posedge iRST) begin
      if (iRST) begin
         r_cnt   <= '0;
         r_phase <= '0;
         r_bck   <= 1'b0;
         r_lrck  <= 1'b0;
         r_sync  <= '0;
         r_sh_l  <= '0;
         r_sh_r  <= '0;
         r_arm   <= 1'b0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         r_phase <= w_ph_nxt;
         r_bck   <= (w_ph_nxt >= c_PH_HALF);
         r_lrck  <= (w_cnt_nxt >= c_CNT_HALF);
         r_sync  <= {r_sync[0], iAUD_ADCDAT};
         if (r_phase == c_PH_CAP) begin
            if (r_lrck)
               r_sh_r <= {r_sh_r[DATA_WIDTH-2:0], r_sync[1]};
            else
               r_sh_l <= {r_sh_l[DATA_WIDTH-2:0], r_sync[1]};
         end
         if (!iEN)
            r_arm <= 1'b0;
         else if (r_cnt == '0)
            r_arm <= 1'b1;
      end
   end

   always_ff @(posedge iCLK_18_4) begin
      if (w_wr) begin
         r_mem_l[r_wptr] <= r_sh_l;
         r_mem_r[r_wptr] <= r_sh_r;
      end
   end

   always_ff @(posedge iCLK_18_4 or posedge iRST) begin
      if (iRST) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_left  <= '0;
         r_right <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + c_AW'(1);
         r_rptr  <= w_rptr_nxt;
         r_level <= w_level_nxt;
         // Head register: a lone new entry bypasses memory; empty holds last pop
         if (w_level_nxt != '0) begin
            if (w_wr && (w_level_nxt == c_LVL_ONE)) begin
               r_left  <= r_sh_l;
               r_right <= r_sh_r;
            end else begin
               r_left  <= r_mem_l[w_rptr_nxt];
               r_right <= r_mem_r[w_rptr_nxt];
            end
         end
         if (w_drop)
            r_ovf <= 1'b1;
         else if (iCLR_OVF)
            r_ovf <= 1'b0;
      end
   end

   assign oAUD_BCK     = r_bck;
   assign oAUD_ADCLRCK = r_lrck;
   assign oVALID       = (r_level != '0);
   assign oLEFT        = r_left;
   assign oRIGHT       = r_right;
   assign oLEVEL       = r_level;
   assign oOVERFLOW    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_audio_adc_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_audio_adc_rx
// Purpose  : Directed, table-driven bench for audio_adc_rx with a codec model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_adc_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        adcdat = 1'b0;
   logic        en = 1'b0;
   logic        rd = 1'b0;
   logic        clr = 1'b0;
   logic        bck, lrck, valid, ovf;
   logic [15:0] left, right;
   logic [2:0]  level;

   audio_adc_rx dut (
      .iCLK_18_4    (clk),
      .iRST         (rst),
      .iAUD_ADCDAT  (adcdat),
      .oAUD_BCK     (bck),
      .oAUD_ADCLRCK (lrck),
      .iEN          (en),
      .iREAD        (rd),
      .iCLR_OVF     (clr),
      .oVALID       (valid),
      .oLEFT        (left),
      .oRIGHT       (right),
      .oLEVEL       (level),
      .oOVERFLOW    (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          exp_level;
      bit          exp_ovf;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;
   int tb_c   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      tb_c = (tb_c + 1) % 384;
   endtask

   task automatic wait_c(input int t);
      int k = 0;
      do begin
         tick();
         k++;
      end while (tb_c != t && k < 800);
      if (tb_c != t) chk("wait_c timeout", tb_c, t);
   endtask

   task automatic pop();
      rd = 1'b1;
      tick();
      rd = 1'b0;
   endtask

   // Codec model: left-justified, MSB first, data changes on falling BCK
   logic [15:0] q_l[$];
   logic [15:0] q_r[$];
   logic [15:0] cod_l = '0, cod_r = '0;
   logic        cod_lr = 1'b0, prev_bck = 1'b0;
   int          idx = 0;

   always @(posedge clk) begin
      #2;
      if (prev_bck && !bck) begin
         if (lrck != cod_lr) begin
            cod_lr = lrck;
            idx = 0;
            if (!lrck) begin
               if (q_l.size() > 0) begin
                  cod_l = q_l.pop_front();
                  cod_r = q_r.pop_front();
               end else begin
                  cod_l = '0;
                  cod_r = '0;
               end
            end
         end else if (idx < 15) begin
            idx++;
         end
         adcdat = cod_lr ? cod_r[15-idx] : cod_l[15-idx];
      end
      prev_bck = bck;
   end

   vec_t tab  [5];
   vec_t tab2 [5];
   int   cnt;

   initial begin
      tab[0] = '{16'h1111, 16'h2222, 1, 1'b0};
      tab[1] = '{16'h2222, 16'h3333, 2, 1'b0};
      tab[2] = '{16'h3333, 16'h4444, 3, 1'b0};
      tab[3] = '{16'h4444, 16'h5555, 4, 1'b0};
      tab[4] = '{16'h5555, 16'h6666, 4, 1'b1};
      for (int i = 0; i < 5; i++)
         tab2[i] = '{16'hA001 + 16'(i), 16'hB001 + 16'(i), (i < 4) ? i + 1 : 4, 1'b0};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst bck", bck, 0);
      chk("rst lrck", lrck, 0);
      chk("rst valid", valid, 0);
      chk("rst level", level, 0);
      chk("rst ovf", ovf, 0);
      chk("rst left", left, 0);
      chk("rst right", right, 0);
      @(negedge clk);
      rst = 1'b0;
      tb_c = 0;

      // Idle clock generation
      for (int i = 0; i < 800; i++) begin
         tick();
         chk("idle bck", bck, (tb_c % 12) >= 6);
         chk("idle lrck", lrck, tb_c >= 192);
         chk("idle valid", valid, 0);
      end

      // Single frame capture
      en = 1'b1;
      q_l.push_back(16'h8001);
      q_r.push_back(16'h7FFE);
      wait_c(0);
      wait_c(380);
      chk("f1 valid at 380", valid, 0);
      tick();
      chk("f1 valid", valid, 1);
      chk("f1 level", level, 1);
      chk("f1 left", left, 16'h8001);
      chk("f1 right", right, 16'h7FFE);
      pop();
      chk("f1 popped valid", valid, 0);
      chk("f1 popped level", level, 0);
      chk("f1 hold left", left, 16'h8001);
      chk("f1 hold right", right, 16'h7FFE);

      // Five frames without reads: overflow on the fifth
      for (int i = 0; i < 5; i++) begin
         q_l.push_back(tab[i].l);
         q_r.push_back(tab[i].r);
      end
      for (int i = 0; i < 5; i++) begin
         wait_c(380);
         tick();
         chk("fill level", level, tab[i].exp_level);
         chk("fill ovf", ovf, tab[i].exp_ovf);
      end
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("drain valid", valid, 1);
         chk("drain left", left, tab[i].l);
         chk("drain right", right, tab[i].r);
         pop();
      end
      chk("drained valid", valid, 0);
      chk("drained level", level, 0);
      chk("drained hold left", left, tab[3].l);
      chk("ovf sticky", ovf, 1);
      pop();
      chk("empty read level", level, 0);
      chk("empty read left", left, tab[3].l);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("ovf cleared", ovf, 0);

      // Full FIFO with pop on the push edge
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         q_l.push_back(tab2[i].l);
         q_r.push_back(tab2[i].r);
      end
      wait_c(0);
      for (int i = 0; i < 4; i++) begin
         wait_c(380);
         tick();
         chk("full level", level, tab2[i].exp_level);
      end
      wait_c(380);
      chk("pre pushpop level", level, 4);
      pop();
      en = 1'b0;
      chk("pushpop level", level, 4);
      chk("pushpop ovf", ovf, 0);
      for (int i = 1; i < 5; i++) begin
         chk("pushpop left", left, tab2[i].l);
         chk("pushpop right", right, tab2[i].r);
         pop();
      end
      chk("pushpop drained", valid, 0);

      // Enable raised mid-frame
      q_l.push_back(16'h0F0F); q_r.push_back(16'hF0F0);
      q_l.push_back(16'h1234); q_r.push_back(16'hABCD);
      q_l.push_back(16'h5A5A); q_r.push_back(16'hA5A5);
      wait_c(0);
      wait_c(100);
      en = 1'b1;
      wait_c(380);
      tick();
      chk("midframe no push", valid, 0);
      chk("midframe level", level, 0);
      wait_c(380);
      tick();
      chk("armed valid", valid, 1);
      chk("armed level", level, 1);
      chk("armed left", left, 16'h1234);
      chk("armed right", right, 16'hABCD);
      wait_c(380);
      tick();
      chk("two frames level", level, 2);
      chk("two frames head", left, 16'h1234);

      // Asynchronous reset mid-frame
      wait_c(250);
      rst = 1'b1;
      #1;
      chk("arst level", level, 0);
      chk("arst valid", valid, 0);
      chk("arst bck", bck, 0);
      chk("arst lrck", lrck, 0);
      chk("arst left", left, 0);
      en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      while (!lrck && cnt < 400) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("lrck first rise", cnt, 192);
      chk("post rst level", level, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
